// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared types for the fetch / decode boundary.
//   if_state_e        : fetch-stage FSM states (FETCH, HOLD, DISCARD)
//   NOP_INSTR_DEFAULT : instruction word used for bubbles unless overridden
//   IF_ID_W           : width of the IF/ID bundle (valid + pc + pc4 + instr = 97)
//   if_id_t           : packed IF/ID bundle
//   if_id_bubble()    : builds a bubble bundle around a given NOP word
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam int unsigned IF_ID_W           = 97;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } if_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

  function automatic if_id_t if_id_bubble(input logic [31:0] nop);
    if_id_t b;
    b.valid = 1'b0;
    b.pc    = 32'h0;
    b.pc4   = 32'h0;
    b.instr = nop;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg -- IF/ID pipeline register with bubble / load / hold control.
//   clk    : clock
//   rst    : asynchronous active-low reset (loads a bubble)
//   load   : capture d
//   bubble : load a bubble; wins over load
//   d      : next IF/ID bundle (IF_ID_W bits)
//   q      : registered IF/ID bundle
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               bubble,
  input  logic [IF_ID_W-1:0] d,
  output logic [IF_ID_W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= if_id_bubble(NOP_INSTR);
    end else if (bubble) begin
      q <= if_id_bubble(NOP_INSTR);
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage -- instruction fetch control and IF/ID register.
//   clk, rst          : clock; asynchronous active-low reset
//   pc_i              : current fetch address
//   if_stall_o        : PC register must hold this cycle
//   imem_req_o/addr_o : instruction memory request and address
//   imem_rdata_i/rvalid_i : instruction memory response (may be zero-wait)
//   stall_i, flush_i  : hazard hold / redirect (flush wins)
//   id_*_o            : registered IF/ID contents
//   stall_cnt_o       : fetch-stall cycle counter, present only when the
//                       IF_STALL_CNT_EN macro is defined, otherwise constant 0
//
// state   | meaning
// --------+-------------------------------------------------------------
// FETCH   | request at pc_i; deliver the response straight into IF/ID
// HOLD    | response parked in skid_q while ID is stalled; no request
// DISCARD | redirect left a request in flight; keep addr, drop its data
module if_id_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic        if_stall_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_rvalid_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc4_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] stall_cnt_o
);

  if_state_e   state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] skid_q;
  logic        addr_load;
  logic        skid_load;
  logic        ifid_load;
  logic        ifid_bubble;
  if_id_t      ifid_d;
  if_id_t      ifid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      addr_q  <= 32'h0;
      skid_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      if (addr_load) addr_q <= pc_i;
      if (skid_load) skid_q <= imem_rdata_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    imem_req_o   = 1'b0;
    imem_addr_o  = addr_q;
    if_stall_o   = 1'b0;
    addr_load    = 1'b0;
    skid_load    = 1'b0;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b0;
    ifid_d.valid = 1'b1;
    ifid_d.pc    = pc_i;
    ifid_d.pc4   = pc_i + 32'd4;
    ifid_d.instr = imem_rdata_i;

    unique case (state_q)
      FETCH: begin
        imem_req_o  = 1'b1;
        imem_addr_o = pc_i;
        addr_load   = 1'b1;
        if (flush_i) begin
          // PC must move to the redirect target; an unanswered request
          // is still owed a response that has to be swallowed.
          ifid_bubble = 1'b1;
          state_d     = imem_rvalid_i ? FETCH : DISCARD;
        end else if (imem_rvalid_i) begin
          if (stall_i) begin
            skid_load  = 1'b1;
            if_stall_o = 1'b1;
            state_d    = HOLD;
          end else begin
            ifid_load  = 1'b1;
          end
        end else begin
          if_stall_o  = 1'b1;
          ifid_bubble = !stall_i;
        end
      end

      HOLD: begin
        // PC was held on entry, so addr_q still names the parked word.
        ifid_d.pc    = addr_q;
        ifid_d.pc4   = addr_q + 32'd4;
        ifid_d.instr = skid_q;
        if (flush_i) begin
          ifid_bubble = 1'b1;
          state_d     = FETCH;
        end else if (!stall_i) begin
          ifid_load   = 1'b1;
          state_d     = FETCH;
        end else begin
          if_stall_o  = 1'b1;
        end
      end

      DISCARD: begin
        imem_req_o  = 1'b1;
        if_stall_o  = 1'b1;
        ifid_bubble = flush_i || !stall_i;
        if (imem_rvalid_i) state_d = FETCH;
      end

      default: begin
        state_d     = FETCH;
        ifid_bubble = 1'b1;
      end
    endcase
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign id_valid_o = ifid_q.valid;
  assign id_pc_o    = ifid_q.pc;
  assign id_pc4_o   = ifid_q.pc4;
  assign id_instr_o = ifid_q.instr;

`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 32'h0;
    end else if (if_stall_o) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;
  import cpu_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        if_stall_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        imem_rvalid_i;
  logic        stall_i;
  logic        flush_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc4_o;
  logic [31:0] id_instr_o;
  logic [31:0] stall_cnt_o;

  if_id_stage #(.NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .if_stall_o    (if_stall_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .imem_rvalid_i (imem_rvalid_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .id_valid_o    (id_valid_o),
    .id_pc_o       (id_pc_o),
    .id_pc4_o      (id_pc4_o),
    .id_instr_o    (id_instr_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        rv;
    logic [31:0] rd;
    logic        st;
    logic        fl;
    logic        e_stall;
    logic        e_req;
    logic [31:0] e_addr;
    if_id_t      e_out;
  } vec_t;

  int     n_cmp = 0;
  int     n_bad = 0;
  if_id_t sb_q[$];
  vec_t   tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic if_id_t bub();
    return if_id_bubble(NOP);
  endfunction

  function automatic if_id_t rec(input logic [31:0] pc, input logic [31:0] pc4,
                                 input logic [31:0] instr);
    if_id_t r;
    r.valid = 1'b1;
    r.pc    = pc;
    r.pc4   = pc4;
    r.instr = instr;
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] pc, input logic rv, input logic [31:0] rd,
                              input logic st, input logic fl, input logic es,
                              input logic er, input logic [31:0] ea, input if_id_t eo);
    vec_t v;
    v.pc = pc; v.rv = rv; v.rd = rd; v.st = st; v.fl = fl;
    v.e_stall = es; v.e_req = er; v.e_addr = ea; v.e_out = eo;
    return v;
  endfunction

  // Drive one cycle of stimulus, check the combinational outputs before the
  // edge, queue the expected IF/ID contents and compare them after the edge.
  task automatic step(input vec_t v, input string tag);
    if_id_t e;
    pc_i          = v.pc;
    imem_rvalid_i = v.rv;
    imem_rdata_i  = v.rd;
    stall_i       = v.st;
    flush_i       = v.fl;
    #2;
    chk($sformatf("%s.if_stall", tag), 32'(if_stall_o), 32'(v.e_stall));
    chk($sformatf("%s.imem_req", tag), 32'(imem_req_o), 32'(v.e_req));
    if (v.e_req) chk($sformatf("%s.imem_addr", tag), imem_addr_o, v.e_addr);
    sb_q.push_back(v.e_out);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk($sformatf("%s.sb_empty", tag), 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk($sformatf("%s.id_valid", tag), 32'(id_valid_o), 32'(e.valid));
      chk($sformatf("%s.id_pc", tag), id_pc_o, e.pc);
      chk($sformatf("%s.id_pc4", tag), id_pc4_o, e.pc4);
      chk($sformatf("%s.id_instr", tag), id_instr_o, e.instr);
    end
  endtask

  task automatic chk_bubble_now(input string tag);
    chk($sformatf("%s.id_valid", tag), 32'(id_valid_o), 32'd0);
    chk($sformatf("%s.id_pc", tag), id_pc_o, 32'h0);
    chk($sformatf("%s.id_pc4", tag), id_pc4_o, 32'h0);
    chk($sformatf("%s.id_instr", tag), id_instr_o, NOP);
    chk($sformatf("%s.stall_cnt", tag), stall_cnt_o, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_cnt;

    rst           = 1'b0;
    pc_i          = 32'h0;
    imem_rdata_i  = 32'h0;
    imem_rvalid_i = 1'b0;
    stall_i       = 1'b0;
    flush_i       = 1'b0;

    tbl[0] = mk(32'h0000_0000, 1, 32'h1111_0001, 0, 0, 0, 1, 32'h0000_0000,
                rec(32'h0000_0000, 32'h0000_0004, 32'h1111_0001));
    tbl[1] = mk(32'h0000_0004, 1, 32'h1111_0002, 0, 0, 0, 1, 32'h0000_0004,
                rec(32'h0000_0004, 32'h0000_0008, 32'h1111_0002));
    tbl[2] = mk(32'h0000_0008, 1, 32'h1111_0003, 0, 0, 0, 1, 32'h0000_0008,
                rec(32'h0000_0008, 32'h0000_000C, 32'h1111_0003));
    tbl[3] = mk(32'h0000_0100, 0, 32'hDEAD_BEEF, 0, 0, 1, 1, 32'h0000_0100, bub());
    tbl[4] = mk(32'h0000_0100, 1, 32'h2222_0001, 0, 0, 0, 1, 32'h0000_0100,
                rec(32'h0000_0100, 32'h0000_0104, 32'h2222_0001));
    tbl[5] = mk(32'h0000_0200, 1, 32'hBAD0_0001, 1, 1, 0, 1, 32'h0000_0200, bub());
    tbl[6] = mk(32'hFFFF_FFFC, 1, 32'h3333_0001, 0, 0, 0, 1, 32'hFFFF_FFFC,
                rec(32'hFFFF_FFFC, 32'h0000_0000, 32'h3333_0001));
    tbl[7] = mk(32'h0000_0300, 0, 32'h0000_0000, 1, 0, 1, 1, 32'h0000_0300,
                rec(32'hFFFF_FFFC, 32'h0000_0000, 32'h3333_0001));
    tbl[8] = mk(32'h0000_0300, 1, 32'h4444_0001, 0, 0, 0, 1, 32'h0000_0300,
                rec(32'h0000_0300, 32'h0000_0304, 32'h4444_0001));

    #12;
    chk_bubble_now("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) step(tbl[i], $sformatf("vec%0d", i));

    // ID stalled on a valid response for three cycles, then released.
    step(mk(32'h400, 1, 32'h2402_0005, 1, 0, 1, 1, 32'h400,
            rec(32'h300, 32'h304, 32'h4444_0001)), "hold0");
    step(mk(32'h400, 0, 32'h0, 1, 0, 1, 0, 32'h0,
            rec(32'h300, 32'h304, 32'h4444_0001)), "hold1");
    step(mk(32'h400, 0, 32'h0, 1, 0, 1, 0, 32'h0,
            rec(32'h300, 32'h304, 32'h4444_0001)), "hold2");
    step(mk(32'h400, 0, 32'h0, 0, 0, 0, 0, 32'h0,
            rec(32'h400, 32'h404, 32'h2402_0005)), "hold_rel");
    step(mk(32'h404, 0, 32'h0, 0, 0, 1, 1, 32'h404, bub()), "hold_once");

    // Redirect with a request in flight; its late response must vanish.
    step(mk(32'h500, 0, 32'h0, 0, 1, 0, 1, 32'h500, bub()), "disc0");
    step(mk(32'h600, 0, 32'h0, 0, 0, 1, 1, 32'h500, bub()), "disc1");
    step(mk(32'h600, 1, 32'hBADB_AD00, 0, 0, 1, 1, 32'h500, bub()), "disc2");
    step(mk(32'h600, 1, 32'h5555_0001, 0, 0, 0, 1, 32'h600,
            rec(32'h600, 32'h604, 32'h5555_0001)), "disc3");

    // Flush while parked in HOLD beats the stall and drops the skid word.
    step(mk(32'h604, 1, 32'h6666_0001, 1, 0, 1, 1, 32'h604,
            rec(32'h600, 32'h604, 32'h5555_0001)), "hflush0");
    step(mk(32'h604, 0, 32'h0, 1, 1, 0, 0, 32'h0, bub()), "hflush1");
    step(mk(32'h800, 1, 32'h7777_0001, 0, 0, 0, 1, 32'h800,
            rec(32'h800, 32'h804, 32'h7777_0001)), "hflush2");

    // Reset asserted while in HOLD.
    step(mk(32'h700, 1, 32'h8888_0001, 1, 0, 1, 1, 32'h700,
            rec(32'h800, 32'h804, 32'h7777_0001)), "rhold");
    pc_i          = 32'h900;
    imem_rvalid_i = 1'b0;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_bubble_now("rst_hold");
    chk("rst_hold.imem_req", 32'(imem_req_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    step(mk(32'h900, 0, 32'h0, 0, 0, 1, 1, 32'h900, bub()), "cnt0");
    step(mk(32'h900, 0, 32'h0, 0, 0, 1, 1, 32'h900, bub()), "cnt1");
    step(mk(32'h900, 1, 32'h9999_0001, 1, 0, 1, 1, 32'h900, bub()), "cnt2");
    step(mk(32'h900, 0, 32'h0, 1, 0, 1, 0, 32'h0, bub()), "cnt3");
    step(mk(32'h900, 0, 32'h0, 0, 0, 0, 0, 32'h0,
            rec(32'h900, 32'h904, 32'h9999_0001)), "cnt4");
`ifdef IF_STALL_CNT_EN
    exp_cnt = 32'd4;
`else
    exp_cnt = 32'd0;
`endif
    chk("stall_cnt_after_reset", stall_cnt_o, exp_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
